// File: rtl/ro_odometer_ctrl.sv
// ro_odometer_ctrl
// Measurement sequencer for the ring-oscillator odometer. It sweeps the
// enabled RO pairs. For each pair it clears the external edge counters,
// gates both oscillators for the programmed window, waits for the counts to
// settle, then captures them. It emits one signed delta (ref - stressed) per
// pair over a valid/ready handshake. While idle it drives the aging stress
// enable.
//
// Optional feature macro: RO_ODOMETER_CTRL_MINMAX_EN
//   When defined, adds max_delta_o / max_idx_o. These track the largest
//   accepted delta of the current sweep and hold it after the sweep ends.
//
// Ports:
//   clk_i, rst_i               clock, asynchronous active-high reset
//   start_i, abort_i           sweep request / abort
//   cfg_window_i               gate length in cycles (0 acts as 1)
//   cfg_mask_i                 pairs included in the sweep
//   cfg_stress_i               stress enable while idle
//   busy_o, done_o             sweep in progress / completion pulse
//   ro_sel_o, ro_en_o          selected pair and its gate enable
//   stress_en_o, cnt_clr_o     stress oscillation enable, counter clear
//   cnt_ref_i, cnt_str_i       synchronized counter values
//   res_valid_o, res_ready_i   result handshake
//   res_idx_o, res_delta_o     pair index and signed delta of the result
//   max_delta_o, max_idx_o     (optional) running maximum delta and its pair
module ro_odometer_ctrl #(
  parameter int NUM_RO     = 8,
  parameter int CNT_W      = 16,
  parameter int WIN_W      = 16,
  parameter int SETTLE_CYC = 4,
  localparam int IDX_W     = $clog2(NUM_RO)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [WIN_W-1:0] cfg_window_i,
  input  logic [NUM_RO-1:0] cfg_mask_i,
  input  logic             cfg_stress_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [IDX_W-1:0] ro_sel_o,
  output logic             ro_en_o,
  output logic             stress_en_o,
  output logic             cnt_clr_o,
  input  logic [CNT_W-1:0] cnt_ref_i,
  input  logic [CNT_W-1:0] cnt_str_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [IDX_W-1:0] res_idx_o,
`ifdef RO_ODOMETER_CTRL_MINMAX_EN
  output logic [CNT_W:0]   res_delta_o,
  output logic [CNT_W:0]   max_delta_o,
  output logic [IDX_W-1:0] max_idx_o
`else
  output logic [CNT_W:0]   res_delta_o
`endif
);

  localparam int SET_W = $clog2(SETTLE_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, SCAN, CLEAR, GATE, SETTLE, CAPTURE, DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [WIN_W-1:0]        win_q;
  logic [NUM_RO-1:0]       mask_q;
  logic [IDX_W:0]          ptr_q;       // one bit wider so it can point past the last pair
  logic [IDX_W-1:0]        sel_q;
  logic [WIN_W-1:0]        gate_cnt_q;
  logic [SET_W-1:0]        settle_cnt_q;
  logic                    res_valid_q;
  logic [IDX_W-1:0]        res_idx_q;
  logic signed [CNT_W:0]   res_delta_q;
  logic                    scan_found;
  logic [IDX_W-1:0]        scan_idx;
  logic                    handshake;
`ifdef RO_ODOMETER_CTRL_MINMAX_EN
  logic signed [CNT_W:0]   max_delta_q;
  logic [IDX_W-1:0]        max_idx_q;
`endif

  // Zero-extend both counts so the full unsigned range gives a correct signed difference.
  function automatic logic signed [CNT_W:0] ref_minus_str(input logic [CNT_W-1:0] r,
                                                          input logic [CNT_W-1:0] s);
    return $signed({1'b0, r}) - $signed({1'b0, s});
  endfunction

  // Lowest enabled pair at or above the sweep pointer; a descending loop leaves the lowest hit.
  always_comb begin
    scan_found = 1'b0;
    scan_idx   = '0;
    for (int i = NUM_RO - 1; i >= 0; i--) begin
      if (mask_q[i] && ((IDX_W + 1)'(i) >= ptr_q)) begin
        scan_found = 1'b1;
        scan_idx   = IDX_W'(i);
      end
    end
  end

  assign handshake = (state_q == CAPTURE) && res_valid_q && res_ready_i && !abort_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = SCAN;
      SCAN:    state_d = scan_found ? CLEAR : DONE;
      CLEAR:   state_d = GATE;
      GATE:    if (gate_cnt_q == WIN_W'(1)) state_d = SETTLE;
      SETTLE:  if (settle_cnt_q == SET_W'(1)) state_d = CAPTURE;
      CAPTURE: if (res_valid_q && res_ready_i) state_d = SCAN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Abort wins over everything, including a result handshake in the same cycle.
    if (abort_i && (state_q != IDLE)) state_d = IDLE;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      win_q        <= '0;
      mask_q       <= '0;
      ptr_q        <= '0;
      sel_q        <= '0;
      gate_cnt_q   <= '0;
      settle_cnt_q <= '0;
      res_valid_q  <= 1'b0;
      res_idx_q    <= '0;
      res_delta_q  <= '0;
`ifdef RO_ODOMETER_CTRL_MINMAX_EN
      max_delta_q  <= '0;
      max_idx_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            win_q  <= cfg_window_i;
            mask_q <= cfg_mask_i;
            ptr_q  <= '0;
`ifdef RO_ODOMETER_CTRL_MINMAX_EN
            max_delta_q <= {1'b1, {CNT_W{1'b0}}};
            max_idx_q   <= '0;
`endif
          end
        end
        SCAN: begin
          if (scan_found) sel_q <= scan_idx;
        end
        CLEAR: begin
          gate_cnt_q <= (win_q == '0) ? WIN_W'(1) : win_q;
        end
        GATE: begin
          gate_cnt_q <= gate_cnt_q - WIN_W'(1);
          if (gate_cnt_q == WIN_W'(1)) settle_cnt_q <= SET_W'(SETTLE_CYC);
        end
        SETTLE: begin
          settle_cnt_q <= settle_cnt_q - SET_W'(1);
        end
        CAPTURE: begin
          // The first cycle samples the settled counters; the fields then hold until accepted.
          if (!res_valid_q) begin
            res_delta_q <= ref_minus_str(cnt_ref_i, cnt_str_i);
            res_idx_q   <= sel_q;
            res_valid_q <= 1'b1;
          end else if (handshake) begin
            res_valid_q <= 1'b0;
            ptr_q       <= {1'b0, sel_q} + (IDX_W + 1)'(1);
`ifdef RO_ODOMETER_CTRL_MINMAX_EN
            // Strictly greater: on a tie the earlier (lower) pair is kept.
            if (res_delta_q > max_delta_q) begin
              max_delta_q <= res_delta_q;
              max_idx_q   <= res_idx_q;
            end
`endif
          end
        end
        default: ;
      endcase
      if (abort_i && (state_q != IDLE)) res_valid_q <= 1'b0;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign done_o      = (state_q == DONE);
  assign ro_en_o     = (state_q == GATE);
  assign cnt_clr_o   = (state_q == CLEAR);
  assign stress_en_o = (state_q == IDLE) && cfg_stress_i;
  assign ro_sel_o    = sel_q;
  assign res_valid_o = res_valid_q;
  assign res_idx_o   = res_idx_q;
  assign res_delta_o = res_delta_q;
`ifdef RO_ODOMETER_CTRL_MINMAX_EN
  assign max_delta_o = max_delta_q;
  assign max_idx_o   = max_idx_q;
`endif

endmodule

// File: tb/tb_ro_odometer_ctrl.sv
// Testbench for ro_odometer_ctrl: table-driven sweeps plus hand-written
// sequences for backpressure, empty mask timing, abort, restart, async reset
// and (when RO_ODOMETER_CTRL_MINMAX_EN is defined) the running maximum.
module tb_ro_odometer_ctrl;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        start_i, abort_i, cfg_stress_i, res_ready_i;
  logic [15:0] cfg_window_i;
  logic [7:0]  cfg_mask_i;
  logic        busy_o, done_o, ro_en_o, stress_en_o, cnt_clr_o, res_valid_o;
  logic [2:0]  ro_sel_o, res_idx_o;
  logic [15:0] cnt_ref_i, cnt_str_i;
  logic [16:0] res_delta_o;
`ifdef RO_ODOMETER_CTRL_MINMAX_EN
  logic [16:0] max_delta_o;
  logic [2:0]  max_idx_o;
`endif

  logic [15:0] ref_arr [8];
  logic [15:0] str_arr [8];
  assign cnt_ref_i = ref_arr[ro_sel_o];
  assign cnt_str_i = str_arr[ro_sel_o];

  always #5 clk = ~clk;

  ro_odometer_ctrl #(.NUM_RO(8), .CNT_W(16), .WIN_W(16), .SETTLE_CYC(4)) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .abort_i(abort_i),
    .cfg_window_i(cfg_window_i), .cfg_mask_i(cfg_mask_i), .cfg_stress_i(cfg_stress_i),
    .busy_o(busy_o), .done_o(done_o), .ro_sel_o(ro_sel_o), .ro_en_o(ro_en_o),
    .stress_en_o(stress_en_o), .cnt_clr_o(cnt_clr_o),
    .cnt_ref_i(cnt_ref_i), .cnt_str_i(cnt_str_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_idx_o(res_idx_o),
`ifdef RO_ODOMETER_CTRL_MINMAX_EN
    .res_delta_o(res_delta_o), .max_delta_o(max_delta_o), .max_idx_o(max_idx_o)
`else
    .res_delta_o(res_delta_o)
`endif
  );

  // Monitor: per-pair gate cycles, done pulses, accepted results.
  logic        mon_clr = 1'b0;
  int          en_cnt [8];
  int          done_cnt;
  logic [16:0] res_d_q [$];
  logic [2:0]  res_i_q [$];

  always @(negedge clk) begin
    if (mon_clr) begin
      for (int i = 0; i < 8; i++) en_cnt[i] = 0;
      done_cnt = 0;
      res_d_q.delete();
      res_i_q.delete();
    end else if (!rst_i) begin
      if (ro_en_o) en_cnt[ro_sel_o] = en_cnt[ro_sel_o] + 1;
      if (done_o) done_cnt = done_cnt + 1;
      if (res_valid_o && res_ready_i) begin
        res_d_q.push_back(res_delta_o);
        res_i_q.push_back(res_idx_o);
      end
    end
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_clr = 1'b1;
    tick();
    mon_clr = 1'b0;
  endtask

  task automatic set_counts(input logic [15:0] r, input logic [15:0] s);
    for (int i = 0; i < 8; i++) begin
      ref_arr[i] = r;
      str_arr[i] = s;
    end
  endtask

  task automatic pulse_start(input logic [7:0] m, input logic [15:0] w);
    cfg_mask_i   = m;
    cfg_window_i = w;
    start_i      = 1'b1;
    tick();
    start_i      = 1'b0;
  endtask

  task automatic wait_done(input string nm);
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (done_o) break;
    end
    chk(nm, done_o, 1);
    tick();
  endtask

  typedef struct {
    logic [7:0]  mask;
    logic [15:0] win;
    logic [15:0] rf;
    logic [15:0] st;
    int          n;
    int          first;
    int          last;
    logic [16:0] delta;
    int          en;
  } vec_t;

  vec_t tab [5];

  initial begin
    tab[0] = '{mask: 8'h05, win: 16'd10, rf: 16'd1000,  st: 16'd990,   n: 2, first: 0, last: 2, delta: 17'h0000A, en: 10};
    tab[1] = '{mask: 8'h80, win: 16'd3,  rf: 16'd5,     st: 16'd5,     n: 1, first: 7, last: 7, delta: 17'h00000, en: 3};
    tab[2] = '{mask: 8'h01, win: 16'd0,  rf: 16'hFFFF,  st: 16'h0000,  n: 1, first: 0, last: 0, delta: 17'h0FFFF, en: 1};
    tab[3] = '{mask: 8'h12, win: 16'd2,  rf: 16'h0000,  st: 16'hFFFF,  n: 2, first: 1, last: 4, delta: 17'h10001, en: 2};
    tab[4] = '{mask: 8'h00, win: 16'd5,  rf: 16'd1,     st: 16'd2,     n: 0, first: 0, last: 0, delta: 17'h00000, en: 0};

    rst_i = 1'b1; start_i = 1'b0; abort_i = 1'b0; cfg_stress_i = 1'b1;
    res_ready_i = 1'b1; cfg_window_i = '0; cfg_mask_i = '0;
    set_counts(16'd0, 16'd0);
    repeat (3) tick();
    rst_i = 1'b0;
    @(negedge clk);

    // Reset / idle state
    chk("rst_stress_en", stress_en_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_ro_en", ro_en_o, 0);
    chk("rst_cnt_clr", cnt_clr_o, 0);
    chk("rst_res_valid", res_valid_o, 0);
    chk("rst_res_delta", res_delta_o, 0);
    chk("rst_res_idx", res_idx_o, 0);
    chk("rst_ro_sel", ro_sel_o, 0);
    cfg_stress_i = 1'b0;
    #1;
    chk("idle_stress_off", stress_en_o, 0);
    cfg_stress_i = 1'b1;

    // Table-driven sweeps, result always accepted
    for (int t = 0; t < 5; t++) begin
      set_counts(tab[t].rf, tab[t].st);
      clear_mon();
      pulse_start(tab[t].mask, tab[t].win);
      wait_done($sformatf("v%0d_done_seen", t));
      chk($sformatf("v%0d_n_results", t), res_d_q.size(), tab[t].n);
      chk($sformatf("v%0d_done_count", t), done_cnt, 1);
      chk($sformatf("v%0d_busy_after", t), busy_o, 0);
      if (tab[t].n > 0) begin
        chk($sformatf("v%0d_first_idx", t), res_i_q[0], tab[t].first);
        chk($sformatf("v%0d_last_idx", t), res_i_q[res_i_q.size()-1], tab[t].last);
        chk($sformatf("v%0d_en_first", t), en_cnt[tab[t].first], tab[t].en);
        foreach (res_d_q[j]) chk($sformatf("v%0d_delta%0d", t, j), res_d_q[j], tab[t].delta);
      end
      begin
        int tot;
        tot = 0;
        for (int i = 0; i < 8; i++) tot += en_cnt[i];
        chk($sformatf("v%0d_en_total", t), tot, tab[t].n * tab[t].en);
      end
    end

    // Backpressure: result fields stay put while ready is low
    set_counts(16'h0010, 16'h0020);
    res_ready_i = 1'b0;
    clear_mon();
    pulse_start(8'h01, 16'd4);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (res_valid_o) break;
    end
    chk("bp_valid_seen", res_valid_o, 1);
    chk("bp_delta", res_delta_o, 17'h1FFF0);
    chk("bp_idx", res_idx_o, 0);
    set_counts(16'h1234, 16'h0001);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_hold_valid", res_valid_o, 1);
      chk("bp_hold_delta", res_delta_o, 17'h1FFF0);
      chk("bp_hold_idx", res_idx_o, 0);
    end
    tick();
    res_ready_i = 1'b1;
    @(negedge clk);
    chk("bp_valid_before_hs", res_valid_o, 1);
    @(negedge clk);
    chk("bp_valid_after_hs", res_valid_o, 0);
    wait_done("bp_done_seen");
    chk("bp_n_results", res_d_q.size(), 1);

    // Empty mask: done exactly two cycles after the start cycle
    cfg_mask_i = 8'h00; cfg_window_i = 16'd7; start_i = 1'b1;
    @(negedge clk);
    chk("empty_c0_done", done_o, 0);
    tick();
    start_i = 1'b0;
    @(negedge clk);
    chk("empty_c1_done", done_o, 0);
    chk("empty_c1_busy", busy_o, 1);
    @(negedge clk);
    chk("empty_c2_done", done_o, 1);
    chk("empty_c2_valid", res_valid_o, 0);
    @(negedge clk);
    chk("empty_c3_done", done_o, 0);
    chk("empty_c3_busy", busy_o, 0);

    // Abort during the gate of pair 3
    set_counts(16'd50, 16'd40);
    clear_mon();
    pulse_start(8'h08, 16'd20);
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ro_en_o && ro_sel_o == 3'd3) break;
    end
    chk("abort_in_gate3", ro_en_o, 1);
    chk("abort_stress_busy", stress_en_o, 0);
    tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy_o, 0);
    chk("abort_ro_en", ro_en_o, 0);
    chk("abort_cnt_clr", cnt_clr_o, 0);
    chk("abort_valid", res_valid_o, 0);
    repeat (30) tick();
    chk("abort_no_done", done_cnt, 0);
    chk("abort_no_result", res_d_q.size(), 0);

    // Restart after abort sweeps from 0; a start mid-sweep changes nothing
    clear_mon();
    pulse_start(8'h09, 16'd6);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ro_en_o) break;
    end
    chk("restart_gate_seen", ro_en_o, 1);
    tick();
    pulse_start(8'hFF, 16'd1);
    cfg_mask_i = 8'h00;
    wait_done("restart_done_seen");
    chk("restart_n_results", res_d_q.size(), 2);
    if (res_i_q.size() == 2) begin
      chk("restart_idx0", res_i_q[0], 0);
      chk("restart_idx1", res_i_q[1], 3);
    end
    chk("restart_en3", en_cnt[3], 6);
    chk("restart_en1", en_cnt[1], 0);
    chk("restart_done_count", done_cnt, 1);
    chk("restart_delta", res_d_q.size() > 0 ? res_d_q[0] : 17'h0, 17'd10);

    // Asynchronous reset mid-gate
    pulse_start(8'h01, 16'd50);
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (ro_en_o) break;
    end
    #2 rst_i = 1'b1;
    #1;
    chk("areset_busy", busy_o, 0);
    chk("areset_ro_en", ro_en_o, 0);
    chk("areset_ro_sel", ro_sel_o, 0);
    tick();
    rst_i = 1'b0;
    tick();

`ifdef RO_ODOMETER_CTRL_MINMAX_EN
    // Running maximum with a tie between pairs 1 and 2
    ref_arr[0] = 16'd105; ref_arr[1] = 16'd112; ref_arr[2] = 16'd112; ref_arr[3] = 16'd97;
    for (int i = 0; i < 8; i++) str_arr[i] = 16'd100;
    clear_mon();
    pulse_start(8'h0F, 16'd3);
    chk("mm_init_delta", max_delta_o, 17'h10000);
    chk("mm_init_idx", max_idx_o, 0);
    wait_done("mm_done_seen");
    chk("mm_n_results", res_d_q.size(), 4);
    repeat (3) tick();
    chk("mm_max_delta", max_delta_o, 17'd12);
    chk("mm_max_idx", max_idx_o, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ro_odometer_ctrl.md
Name: ro_odometer_ctrl

Overview:
Measurement sequencer for the ring-oscillator odometer peripheral (AXI slave at 0x6000_0000, 64 KiB window).
- Sweeps the enabled RO pairs and, for each pair, clears the external reference/stressed edge counters, gates both oscillators for a programmed window, waits for the counts to settle, then captures them.
- Emits one signed delta (ref − stressed) per pair over a valid/ready handshake.
- Drives the stress-enable for aging between sweeps.
- Sits between the odometer register file and the RO/counter macro.

Parameters:
NUM_RO, 8, number of RO pairs (≥2)
CNT_W, 16, width of each external edge counter
WIN_W, 16, width of gate-window length in clk_i cycles
SETTLE_CYC, 4, cycles waited after gate close before capture (CDC settling, ≥1)

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous reset, active-high
start_i  in  1  single-cycle sweep request
abort_i  in  1  abort current sweep
cfg_window_i  in  WIN_W  gate length in cycles; 0 treated as 1
cfg_mask_i  in  NUM_RO  pairs included in sweep
cfg_stress_i  in  1  enable stress mode while idle
busy_o  out  1  sweep in progress
done_o  out  1  one-cycle pulse at sweep completion
ro_sel_o  out  $clog2(NUM_RO)  selected pair index
ro_en_o  out  1  gate enable to selected pair
stress_en_o  out  1  stress oscillation enable, all pairs
cnt_clr_o  out  1  counter clear pulse
cnt_ref_i  in  CNT_W  reference counter value, synchronized
cnt_str_i  in  CNT_W  stressed counter value, synchronized
res_valid_o  out  1  result valid
res_ready_i  in  1  result accepted
res_idx_o  out  $clog2(NUM_RO)  pair index of result
res_delta_o  out  CNT_W+1  signed cnt_ref_i − cnt_str_i

Behaviour:
- Reset: all outputs 0; state IDLE; window/mask latches 0.
- FSM states: IDLE, SCAN, CLEAR, GATE, SETTLE, CAPTURE, DONE.
- IDLE:
  - stress_en_o = cfg_stress_i; busy_o = 0.
  - start_i latches cfg_window_i and cfg_mask_i, then goes to SCAN.
  - Config changes mid-sweep have no effect.
- SCAN (1 cycle): find the lowest set mask bit at index ≥ current pointer.
  - Found: set ro_sel_o to that index, go to CLEAR.
  - None: go to DONE.
  - The pointer starts at 0 for each sweep.
- CLEAR: cnt_clr_o = 1 for exactly 1 cycle, then GATE.
- GATE:
  - ro_en_o = 1 for exactly max(window, 1) cycles; down-counter loaded with the latched window.
  - Then SETTLE.
- SETTLE: ro_en_o = 0 for SETTLE_CYC cycles, then CAPTURE.
- CAPTURE:
  - On the first cycle, register res_delta_o = zero-extended ref − zero-extended str (CNT_W+1 bits, two's complement) and res_idx_o = ro_sel_o.
  - Assert res_valid_o. res_valid_o and all result fields stay stable until res_ready_i is sampled high.
  - On handshake: res_valid_o drops next cycle, pointer = ro_sel_o + 1, go to SCAN.
  - res_ready_i is ignored when res_valid_o = 0.
- DONE: done_o = 1 for 1 cycle, then IDLE.
- Sweep timing: busy_o = 1 in every state except IDLE. stress_en_o = 0 in every state except IDLE.
- Pointer wrap: if ro_sel_o = NUM_RO−1, the handshake sends SCAN straight to DONE, with no wrap to 0.
- Empty mask: start → SCAN → DONE; done_o rises 2 cycles after start; no results.
- start_i while busy: ignored.
- abort_i (any state except IDLE):
  - Next state IDLE; ro_en_o, cnt_clr_o and res_valid_o go to 0 next cycle.
  - No done_o pulse.
  - abort_i has priority over a simultaneous res_ready_i handshake; that result is dropped.
- Asynchronous reset mid-sweep: immediate return to the reset values above.

Optional Feature:
RO_ODOMETER_CTRL_MINMAX_EN
- Defined:
  - Adds outputs max_delta_o (CNT_W+1) and max_idx_o ($clog2(NUM_RO)).
  - Both clear to the most-negative value / 0 on each start.
  - On each accepted result, they update when the signed res_delta_o is strictly greater than max_delta_o; ties keep the lower index.
  - Both are held after done_o.
- Undefined: ports absent, no extra logic.

Test Plan:
- Reset, then idle with cfg_stress_i = 1 → stress_en_o = 1, busy_o = 0, all other outputs 0.
- mask = 8'b0000_0101, window = 10, res_ready_i tied 1, ref = 1000, str = 990 → results idx 0 then idx 2, delta = +10 each; ro_en_o high exactly 10 cycles per pair; one done_o.
- ref = 0x0010, str = 0x0020 → res_delta_o = 17'h1FFF0 (−16); res_ready_i held low 5 cycles → valid and fields stable throughout.
- mask = 0 → done_o exactly 2 cycles after start_i; res_valid_o never asserted. window = 0 with mask = 1 → ro_en_o high 1 cycle.
- abort_i during GATE of pair 3 → next cycle busy_o = 0, ro_en_o = 0; no done_o; a later start sweeps from index 0. start_i pulsed mid-sweep → no effect.
- With RO_ODOMETER_CTRL_MINMAX_EN, deltas +5 / +12 / +12 / −3 on pairs 0–3 → max_delta_o = 12, max_idx_o = 1.
